sample_framer: RTL and testbench
================================

// Module: sample_framer
// PURPOSE
//  Parametrised successor to the ADC FIFO -> byte splitter -> UART path. Pops CHANNELS sample
//  words from the ADC sample FIFO per frame and serialises them into UART bytes: a sync byte,
//  the payload bytes, and an optional XOR checksum. Sits between the ADC sample FIFO (read side)
//  and the UART transmitter, so the host can find frame boundaries and detect corrupted frames.
// PARAMETERS
//  WORD_W      32     FIFO word width in bits; multiple of 8, 8..64; NB = WORD_W/8 bytes per word
//  CHANNELS    2      words (channels) per frame, 1..8
//  SYNC_BYTE   8'hA5  first byte of every frame
//  CHECKSUM_EN 1      1: append XOR-of-payload byte after payload; 0: no checksum byte
//  MSB_FIRST   1      1: send each word most-significant byte first; 0: least-significant first
//  FCNT_W      16     width of frame_cnt
// PORTS
//  clk          in   1        system clock
//  rst          in   1        asynchronous reset, active-high
//  en           in   1        frame start enable; sampled only in IDLE
//  fifo_empty   in   1        FIFO empty flag
//  fifo_dout    in   WORD_W   FIFO read data; valid the cycle after fifo_rd_en (1-cycle latency)
//  fifo_rd_en   out  1        FIFO pop strobe, one cycle per word
//  tx_ready     in   1        UART idle; UART drops it the cycle after tx_start
//  tx_start     out  1        one-cycle strobe: UART takes tx_data
//  tx_data      out  8        byte to send; held stable from tx_start until the next tx_start
//  busy         out  1        high whenever state != IDLE
//  frame_cnt    out  FCNT_W   frames fully sent; wraps to 0 after all ones
// BEHAVIOUR
//  Reset: async; all state cleared. fifo_rd_en=0, tx_start=0, tx_data=0, busy=0, frame_cnt=0.
//   FSM=IDLE, checksum=0, byte/channel counters=0. A partial frame is dropped, not resumed.
//  FSM states: IDLE, SYNC, FETCH, LATCH, SEND, WAIT, CSUM.
//  IDLE:  en && !fifo_empty -> SYNC. The first pop is not issued from IDLE.
//  SYNC:  on tx_ready, tx_data=SYNC_BYTE, tx_start=1, clear checksum -> WAIT (next=FETCH).
//  FETCH: fifo_empty -> stay, no strobes (stall, no abort). Else fifo_rd_en=1 -> LATCH.
//  LATCH: capture fifo_dout into shift register; byte idx=0 -> SEND.
//  SEND:  on tx_ready, drive selected byte with tx_start=1; checksum ^= byte -> WAIT.
//   Byte select: MSB_FIRST ? word[WORD_W-1-8i -: 8] : word[8i +: 8].
//  WAIT:  ignore tx_ready for the cycle after tx_start, then wait for tx_ready=1. Next state:
//   - more bytes in the word -> SEND
//   - last byte, more channels -> FETCH
//   - last byte, last channel -> CSUM if CHECKSUM_EN, else done
//  CSUM:  on tx_ready, tx_data=checksum, tx_start=1 -> WAIT (then done).
//  Done: frame_cnt += 1 (mod 2^FCNT_W) in the cycle the final WAIT sees tx_ready; then -> IDLE.
//  Frame length: 1 + CHANNELS*NB + CHECKSUM_EN bytes. Checksum covers payload only, not sync.
//  Latency: IDLE->first tx_start = 1 cycle when tx_ready=1.
//   Back-to-back bytes gated only by the UART. Each word costs 2 cycles (FETCH, LATCH) when not empty.
//  en dropping mid-frame: frame completes, no new frame starts.
//  tx_start and fifo_rd_en are never high in the same cycle. Never more than one tx_start per byte.
//  Exactly CHANNELS pops per frame. No pop is issued while fifo_empty=1.
// TESTING
//  T1 WORD_W=32,CH=1,CSUM=1,MSB=1: FIFO 0x12345678 -> bytes A5 12 34 56 78 08; frame_cnt 0->1.
//  T2 CH=2,MSB_FIRST=0: words 0x00000001,0xFF000000 -> A5 01 00 00 00 00 00 00 FF FE.
//  T3 FIFO empty after word 0 for 50 cycles: no fifo_rd_en/tx_start while empty.
//   On refill, frame resumes with word 1 bytes; exactly 2 pops total.
//  T4 tx_ready held low 100 cycles mid-frame: no extra tx_start, tx_data stable;
//   release -> next byte within 1 cycle.
//  T5 rst asserted after 3rd tx_start: outputs 0 same cycle. After release with en=1,
//   next byte out is A5; the remaining FIFO words are framed cleanly.
//  T6 FCNT_W=4, CSUM=0: 16 frames back-to-back -> frame_cnt 15 then wraps to 0.
//   en=0 mid-frame -> frame finishes, busy falls, no new frame.

Source files
------------

// File: rtl/sample_framer_if.sv
// sample_framer_if
//   Bundles the two handshakes the framer sits between: the read side of the
//   ADC sample FIFO and the byte input of the UART transmitter.
//   master modport: the framer (pops words, issues bytes).
//   slave modport : the FIFO/UART side (supplies words, accepts bytes).
//   Signals:
//     fifo_empty  FIFO empty flag
//     fifo_dout   FIFO read data, valid the cycle after fifo_rd_en
//     fifo_rd_en  FIFO pop strobe
//     tx_ready    UART idle
//     tx_start    one-cycle strobe, UART takes tx_data
//     tx_data     byte to send
interface sample_framer_if #(
  parameter int WORD_W = 32
);
  logic              fifo_empty;
  logic [WORD_W-1:0] fifo_dout;
  logic              fifo_rd_en;
  logic              tx_ready;
  logic              tx_start;
  logic [7:0]        tx_data;

  modport master (
    input  fifo_empty, fifo_dout, tx_ready,
    output fifo_rd_en, tx_start, tx_data
  );

  modport slave (
    output fifo_empty, fifo_dout, tx_ready,
    input  fifo_rd_en, tx_start, tx_data
  );
endinterface

// File: rtl/sample_framer.sv
// sample_framer
//   Pops CHANNELS words per frame from the ADC sample FIFO and serialises them
//   into UART bytes: SYNC_BYTE, the payload bytes of every word (MSB or LSB
//   first), and optionally an XOR checksum over the payload.
//   Ports:
//     clk        system clock
//     rst        asynchronous reset, active-high
//     en         frame start enable, sampled only while idle
//     bus        FIFO read side + UART byte side (sample_framer_if.master)
//     busy       high whenever a frame is in progress
//     frame_cnt  number of frames fully sent, wraps
module sample_framer #(
  parameter int          WORD_W      = 32,
  parameter int          CHANNELS    = 2,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter bit          CHECKSUM_EN = 1'b1,
  parameter bit          MSB_FIRST   = 1'b1,
  parameter int          FCNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  sample_framer_if.master   bus,
  output logic              busy,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int NB   = WORD_W / 8;
  localparam int BI_W = (NB > 1) ? $clog2(NB) : 1;
  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [BI_W-1:0] LAST_BYTE = BI_W'(NB - 1);
  localparam logic [CH_W-1:0] LAST_CH   = CH_W'(CHANNELS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC, S_FETCH, S_LATCH, S_SEND, S_WAIT, S_CSUM
  } state_t;

  // What the byte just handed to the UART was; decides where WAIT goes next.
  typedef enum logic [1:0] {
    W_SYNC, W_BYTE, W_CSUM
  } wkind_t;

  state_t            state_q,    state_d;
  wkind_t            wkind_q,    wkind_d;
  logic              skip_q,     skip_d;
  logic [BI_W-1:0]   byte_idx_q, byte_idx_d;
  logic [CH_W-1:0]   ch_idx_q,   ch_idx_d;
  logic [WORD_W-1:0] word_q,     word_d;
  logic [7:0]        csum_q,     csum_d;
  logic [7:0]        tx_data_q,  tx_data_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic       rd_en;
  logic       start;
  logic [7:0] tx_byte;
  logic [7:0] cur_byte;

  function automatic logic [7:0] sel_byte(input logic [WORD_W-1:0] w,
                                          input logic [BI_W-1:0]   idx);
    logic [7:0] b;
    b = '0;
    for (int k = 0; k < NB; k++) begin
      if (idx == BI_W'(k)) begin
        b = MSB_FIRST ? w[WORD_W-1-8*k -: 8] : w[8*k +: 8];
      end
    end
    return b;
  endfunction

  assign cur_byte = sel_byte(word_q, byte_idx_q);

  always_comb begin
    state_d     = state_q;
    wkind_d     = wkind_q;
    skip_d      = skip_q;
    byte_idx_d  = byte_idx_q;
    ch_idx_d    = ch_idx_q;
    word_d      = word_q;
    csum_d      = csum_q;
    frame_cnt_d = frame_cnt_q;
    rd_en       = 1'b0;
    start       = 1'b0;
    // tx_data shows the held byte except in a strobe cycle, where it shows
    // the new byte so the UART captures it together with tx_start.
    tx_byte     = tx_data_q;

    case (state_q)
      S_IDLE: begin
        if (en && !bus.fifo_empty) state_d = S_SYNC;
      end
      S_SYNC: begin
        if (bus.tx_ready) begin
          start    = 1'b1;
          tx_byte  = SYNC_BYTE;
          csum_d   = '0;
          ch_idx_d = '0;
          wkind_d  = W_SYNC;
          skip_d   = 1'b1;
          state_d  = S_WAIT;
        end
      end
      S_FETCH: begin
        // An empty FIFO stalls the frame; it never aborts it.
        if (!bus.fifo_empty) begin
          rd_en   = 1'b1;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        word_d     = bus.fifo_dout;
        byte_idx_d = '0;
        state_d    = S_SEND;
      end
      S_SEND: begin
        if (bus.tx_ready) begin
          start   = 1'b1;
          tx_byte = cur_byte;
          csum_d  = csum_q ^ cur_byte;
          wkind_d = W_BYTE;
          skip_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // The UART only drops tx_ready the cycle after tx_start, so the first
        // WAIT cycle would still see a stale ready; skip it.
        if (skip_q) begin
          skip_d = 1'b0;
        end else if (bus.tx_ready) begin
          case (wkind_q)
            W_SYNC: state_d = S_FETCH;
            W_BYTE: begin
              if (byte_idx_q != LAST_BYTE) begin
                byte_idx_d = byte_idx_q + 1'b1;
                state_d    = S_SEND;
              end else if (ch_idx_q != LAST_CH) begin
                ch_idx_d = ch_idx_q + 1'b1;
                state_d  = S_FETCH;
              end else if (CHECKSUM_EN) begin
                state_d = S_CSUM;
              end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
                state_d     = S_IDLE;
              end
            end
            W_CSUM: begin
              frame_cnt_d = frame_cnt_q + 1'b1;
              state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_CSUM: begin
        if (bus.tx_ready) begin
          start   = 1'b1;
          tx_byte = csum_q;
          wkind_d = W_CSUM;
          skip_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    tx_data_d = tx_byte;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wkind_q     <= W_SYNC;
      skip_q      <= 1'b0;
      byte_idx_q  <= '0;
      ch_idx_q    <= '0;
      word_q      <= '0;
      csum_q      <= '0;
      tx_data_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wkind_q     <= wkind_d;
      skip_q      <= skip_d;
      byte_idx_q  <= byte_idx_d;
      ch_idx_q    <= ch_idx_d;
      word_q      <= word_d;
      csum_q      <= csum_d;
      tx_data_q   <= tx_data_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.tx_start   = start;
  assign bus.tx_data    = tx_byte;
  assign busy           = (state_q != S_IDLE);
  assign frame_cnt      = frame_cnt_q;

endmodule

// File: tb/tb_sample_framer.sv
module tb_sample_framer;

  localparam int UART_GAP = 3;

  bit   clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Per-instance bench-side signals. Instance 0: 32b, 1 ch, csum, MSB first.
  // Instance 1: 32b, 2 ch, csum, LSB first. Instance 2: 16b, 1 ch, no csum, 4b count.
  logic        en  [3];
  logic        emp [3];
  logic [31:0] fdout [3];
  logic        rd  [3];
  bit          rdy [3];
  bit          hold [3];
  logic        st  [3];
  logic [7:0]  td  [3];
  logic        bz  [3];
  logic [15:0] fc  [3];
  logic [15:0] fc0_raw, fc1_raw;
  logic [3:0]  fc2_raw;

  logic [31:0] mem [3][64];
  int          wp [3];
  int          rp [3];
  int          ucnt [3];
  int          txcnt [3];
  int          rdcnt [3];
  logic [7:0]  last_td [3];
  logic [7:0]  expq [3][$];

  int errors = 0;
  int checks = 0;

  sample_framer_if #(.WORD_W(32)) if0 ();
  sample_framer_if #(.WORD_W(32)) if1 ();
  sample_framer_if #(.WORD_W(16)) if2 ();

  sample_framer #(.WORD_W(32), .CHANNELS(1), .SYNC_BYTE(8'hA5), .CHECKSUM_EN(1'b1),
                  .MSB_FIRST(1'b1), .FCNT_W(16))
    u0 (.clk(clk), .rst(rst), .en(en[0]), .bus(if0.master), .busy(bz[0]), .frame_cnt(fc0_raw));
  sample_framer #(.WORD_W(32), .CHANNELS(2), .SYNC_BYTE(8'hA5), .CHECKSUM_EN(1'b1),
                  .MSB_FIRST(1'b0), .FCNT_W(16))
    u1 (.clk(clk), .rst(rst), .en(en[1]), .bus(if1.master), .busy(bz[1]), .frame_cnt(fc1_raw));
  sample_framer #(.WORD_W(16), .CHANNELS(1), .SYNC_BYTE(8'hA5), .CHECKSUM_EN(1'b0),
                  .MSB_FIRST(1'b1), .FCNT_W(4))
    u2 (.clk(clk), .rst(rst), .en(en[2]), .bus(if2.master), .busy(bz[2]), .frame_cnt(fc2_raw));

  assign fc[0] = fc0_raw;
  assign fc[1] = fc1_raw;
  assign fc[2] = {12'd0, fc2_raw};

  assign if0.fifo_empty = emp[0];
  assign if1.fifo_empty = emp[1];
  assign if2.fifo_empty = emp[2];
  assign if0.fifo_dout  = fdout[0];
  assign if1.fifo_dout  = fdout[1];
  assign if2.fifo_dout  = fdout[2][15:0];
  assign if0.tx_ready   = rdy[0];
  assign if1.tx_ready   = rdy[1];
  assign if2.tx_ready   = rdy[2];
  assign rd[0] = if0.fifo_rd_en;
  assign rd[1] = if1.fifo_rd_en;
  assign rd[2] = if2.fifo_rd_en;
  assign st[0] = if0.tx_start;
  assign st[1] = if1.tx_start;
  assign st[2] = if2.tx_start;
  assign td[0] = if0.tx_data;
  assign td[1] = if1.tx_data;
  assign td[2] = if2.tx_data;

  always_comb begin
    for (int i = 0; i < 3; i++) emp[i] = (wp[i] == rp[i]);
  end

  // FIFO read side (1-cycle latency) and UART ready model.
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd[i]) begin
        fdout[i] <= mem[i][rp[i]];
        rp[i]    <= rp[i] + 1;
      end
      if (st[i]) begin
        ucnt[i] <= UART_GAP;
        rdy[i]  <= 1'b0;
      end else if (ucnt[i] != 0) begin
        ucnt[i] <= ucnt[i] - 1;
        rdy[i]  <= 1'b0;
      end else begin
        rdy[i] <= !hold[i];
      end
    end
  end

  // Scoreboard monitor: every tx_start pops one expected byte.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (st[i]) begin
        txcnt[i]++;
        checks++;
        if (expq[i].size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte inst%0d: got %02h required no byte", i, td[i]);
        end else begin
          logic [7:0] e;
          e = expq[i].pop_front();
          if (td[i] !== e) begin
            errors++;
            $display("FAIL byte inst%0d: got %02h required %02h", i, td[i], e);
          end
        end
      end else if (!rst && td[i] !== last_td[i]) begin
        checks++;
        errors++;
        $display("FAIL tx_data_stable inst%0d: got %02h required %02h", i, td[i], last_td[i]);
      end
      last_td[i] = td[i];
      if (rd[i]) begin
        rdcnt[i]++;
        if (emp[i] || st[i]) begin
          checks++;
          errors++;
          $display("FAIL pop_protocol inst%0d: got empty=%0d start=%0d required 0 0", i, emp[i], st[i]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, got, exp);
    end
  endtask

  task automatic push(input int i, input logic [31:0] w);
    mem[i][wp[i]] = w;
    wp[i] = wp[i] + 1;
  endtask

  task automatic expb(input int i, input logic [7:0] b);
    expq[i].push_back(b);
  endtask

  task automatic wait_idle(input int i, input int lim);
    int n;
    n = 0;
    tick();
    while ((bz[i] || expq[i].size() != 0) && n < lim) begin
      tick();
      n++;
    end
    if (n >= lim) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout inst%0d: got busy=%0d pending=%0d required 0 0", i, bz[i], expq[i].size());
    end
  endtask

  task automatic wait_tx(input int i, input int target, input int lim);
    int n;
    n = 0;
    while (txcnt[i] < target && n < lim) begin
      tick();
      n++;
    end
    if (n >= lim) begin
      checks++;
      errors++;
      $display("FAIL tx_timeout inst%0d: got %0d bytes required %0d", i, txcnt[i], target);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_tx, base_rd;
    logic [15:0] prev;
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0; wp[i] = 0; rp[i] = 0; txcnt[i] = 0; rdcnt[i] = 0;
    end
    rst = 1'b1;
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("reset_busy%0d", i), {31'd0, bz[i]}, 32'd0);
      chk($sformatf("reset_tx_start%0d", i), {31'd0, st[i]}, 32'd0);
      chk($sformatf("reset_rd_en%0d", i), {31'd0, rd[i]}, 32'd0);
      chk($sformatf("reset_tx_data%0d", i), {24'd0, td[i]}, 32'd0);
      chk($sformatf("reset_frame_cnt%0d", i), {16'd0, fc[i]}, 32'd0);
    end
    rst = 1'b0;
    tick(); tick(); tick(); tick(); tick();

    // T1: single word, MSB first, checksum 12^34^56^78 = 08.
    push(0, 32'h12345678);
    expb(0, 8'hA5); expb(0, 8'h12); expb(0, 8'h34); expb(0, 8'h56); expb(0, 8'h78); expb(0, 8'h08);
    en[0] = 1'b1;
    tick();
    wait_idle(0, 200);
    en[0] = 1'b0;
    chk("t1_frame_cnt", {16'd0, fc[0]}, 32'd1);
    chk("t1_pops", rdcnt[0], 32'd1);

    // T2: two words LSB first, checksum 01^FF = FE.
    push(1, 32'h00000001); push(1, 32'hFF000000);
    expb(1, 8'hA5);
    expb(1, 8'h01); expb(1, 8'h00); expb(1, 8'h00); expb(1, 8'h00);
    expb(1, 8'h00); expb(1, 8'h00); expb(1, 8'h00); expb(1, 8'hFF);
    expb(1, 8'hFE);
    en[1] = 1'b1;
    tick();
    wait_idle(1, 300);
    en[1] = 1'b0;
    chk("t2_frame_cnt", {16'd0, fc[1]}, 32'd1);
    chk("t2_pops", rdcnt[1], 32'd2);

    // T3: FIFO runs dry after word 0; frame stalls in place and resumes.
    base_tx = txcnt[1];
    base_rd = rdcnt[1];
    push(1, 32'hA1B2C3D4);
    expb(1, 8'hA5); expb(1, 8'hD4); expb(1, 8'hC3); expb(1, 8'hB2); expb(1, 8'hA1);
    en[1] = 1'b1;
    wait_tx(1, base_tx + 5, 200);
    repeat (6) tick();
    for (int k = 0; k < 50; k++) tick();
    chk("t3_stall_pops", rdcnt[1] - base_rd, 32'd1);
    chk("t3_stall_bytes", txcnt[1] - base_tx, 32'd5);
    chk("t3_stall_busy", {31'd0, bz[1]}, 32'd1);
    expb(1, 8'h10); expb(1, 8'h00); expb(1, 8'h00); expb(1, 8'h00); expb(1, 8'h14);
    push(1, 32'h00000010);
    wait_idle(1, 300);
    en[1] = 1'b0;
    chk("t3_total_pops", rdcnt[1] - base_rd, 32'd2);
    chk("t3_frame_cnt", {16'd0, fc[1]}, 32'd2);

    // T4: UART held busy mid-frame; checksum DE^AD^BE^EF = 22.
    base_tx = txcnt[0];
    push(0, 32'hDEADBEEF);
    expb(0, 8'hA5); expb(0, 8'hDE); expb(0, 8'hAD); expb(0, 8'hBE); expb(0, 8'hEF); expb(0, 8'h22);
    en[0] = 1'b1;
    wait_tx(0, base_tx + 2, 200);
    hold[0] = 1'b1;
    for (int k = 0; k < 100; k++) tick();
    chk("t4_hold_bytes", txcnt[0] - base_tx, 32'd2);
    chk("t4_hold_data", {24'd0, td[0]}, 32'h000000DE);
    hold[0] = 1'b0;
    tick(); tick();
    chk("t4_release_start", {31'd0, st[0]}, 32'd1);
    chk("t4_release_data", {24'd0, td[0]}, 32'h000000AD);
    wait_idle(0, 200);
    en[0] = 1'b0;
    chk("t4_frame_cnt", {16'd0, fc[0]}, 32'd2);

    // T5: reset after the third byte; the next frame restarts from the sync byte.
    base_tx = txcnt[0];
    base_rd = rdcnt[0];
    push(0, 32'h11223344); push(0, 32'h55667788);
    expb(0, 8'hA5); expb(0, 8'h11); expb(0, 8'h22);
    en[0] = 1'b1;
    wait_tx(0, base_tx + 3, 200);
    rst = 1'b1;
    #1;
    chk("t5_rst_busy", {31'd0, bz[0]}, 32'd0);
    chk("t5_rst_tx_start", {31'd0, st[0]}, 32'd0);
    chk("t5_rst_rd_en", {31'd0, rd[0]}, 32'd0);
    chk("t5_rst_tx_data", {24'd0, td[0]}, 32'd0);
    chk("t5_rst_frame_cnt", {16'd0, fc[0]}, 32'd0);
    expb(0, 8'hA5); expb(0, 8'h55); expb(0, 8'h66); expb(0, 8'h77); expb(0, 8'h88); expb(0, 8'hCC);
    tick();
    rst = 1'b0;
    wait_idle(0, 300);
    en[0] = 1'b0;
    chk("t5_frame_cnt", {16'd0, fc[0]}, 32'd1);
    chk("t5_pops", rdcnt[0] - base_rd, 32'd2);

    // T6: 16 back-to-back frames on a 4-bit counter, then an en drop mid-frame.
    for (int k = 0; k < 16; k++) begin
      logic [7:0] hi, lo;
      hi = 8'(k);
      lo = 8'(k) ^ 8'h5A;
      push(2, {16'd0, hi, lo});
      expb(2, 8'hA5); expb(2, hi); expb(2, lo);
    end
    en[2] = 1'b1;
    prev = fc[2];
    for (int k = 1; k <= 16; k++) begin
      int n;
      n = 0;
      while (fc[2] == prev && n < 200) begin
        tick();
        n++;
      end
      chk($sformatf("t6_frame_cnt_%0d", k), {16'd0, fc[2]}, 32'(k % 16));
      prev = fc[2];
    end
    wait_idle(2, 200);
    en[2] = 1'b0;
    tick();
    base_tx = txcnt[2];
    base_rd = rdcnt[2];
    push(2, 32'h00001234); push(2, 32'h00005678);
    expb(2, 8'hA5); expb(2, 8'h12); expb(2, 8'h34);
    en[2] = 1'b1;
    wait_tx(2, base_tx + 1, 200);
    en[2] = 1'b0;
    wait_idle(2, 200);
    for (int k = 0; k < 20; k++) tick();
    chk("t6_endrop_frame_cnt", {16'd0, fc[2]}, 32'd1);
    chk("t6_endrop_busy", {31'd0, bz[2]}, 32'd0);
    chk("t6_endrop_pops", rdcnt[2] - base_rd, 32'd1);
    chk("t6_endrop_bytes", txcnt[2] - base_tx, 32'd3);

    for (int i = 0; i < 3; i++) chk($sformatf("pending_bytes%0d", i), expq[i].size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
